// File: rtl/frogger_pkg.sv
// Shared state encodings, default game parameters and level arithmetic for the
// Frogger game controller.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int DEATH_FRAMES_DEF = 60;
  localparam int LEVEL_FRAMES_DEF = 90;
  localparam int MAX_LEVEL_DEF    = 99;
  localparam int GOAL_ROW_DEF     = 0;

  localparam int TIMER_W = 7;
  localparam int LEVEL_W = 7;
  localparam int LIVES_W = 2;
  localparam int ROW_W   = 6;

  // Saturating level increment; the level never wraps past max_lvl.
  function automatic logic [LEVEL_W-1:0] level_inc_sat(
    input logic [LEVEL_W-1:0] lvl,
    input logic [LEVEL_W-1:0] max_lvl
  );
    if (lvl >= max_lvl) return max_lvl;
    else                return lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-count down-counter: load has priority, decrements on each frame tick,
// and flags the tick that consumes the final count.
module frame_timer #(
  parameter int WIDTH = 7
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = tick && (count == WIDTH'(1));

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game-flow controller: start, play, death animation, level-up pause
// and game over, with registered outputs for the video and movement logic.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | after reset, waiting for a start press
//   PLAY       | frog and cars moving, watching for collision or goal
//   DYING      | frog frozen and blinking for DEATH_FRAMES frames
//   LEVEL_UP   | everything frozen for LEVEL_FRAMES frames, then level+1
//   GAME_OVER  | no lives left, level/lives held until the next start
module frogger_game_fsm
  import frogger_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int LEVEL_FRAMES = LEVEL_FRAMES_DEF,
  parameter int MAX_LEVEL    = MAX_LEVEL_DEF,
  parameter int GOAL_ROW     = GOAL_ROW_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Frame_Tick,
  input  logic               i_Game_Start,
  input  logic               i_Collided,
  input  logic [ROW_W-1:0]   i_Frog_Y,
  output logic [2:0]         o_State,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [LIVES_W-1:0] o_Lives,
  output logic               o_Frog_Reset,
  output logic               o_Move_En,
  output logic               o_Cars_En,
  output logic               o_Flash
);

  game_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               frog_reset_q, frog_reset_d;
  logic               move_en_q, move_en_d;
  logic               cars_en_q, cars_en_d;
  logic               flash_q, flash_d;
  logic [2:0]         flash_cnt_q, flash_cnt_d;
  logic               start_prev_q;
  logic               start_evt;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_done;

  // Reset value of 1 means a button held through reset is not a start.
  assign start_evt = i_Game_Start && !start_prev_q;

  frame_timer #(
    .WIDTH (TIMER_W)
  ) u_frame_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (i_Frame_Tick),
    .done     (timer_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      lives_q      <= '0;
      frog_reset_q <= 1'b0;
      move_en_q    <= 1'b0;
      cars_en_q    <= 1'b0;
      flash_q      <= 1'b0;
      flash_cnt_q  <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      frog_reset_q <= frog_reset_d;
      move_en_q    <= move_en_d;
      cars_en_q    <= cars_en_d;
      flash_q      <= flash_d;
      flash_cnt_q  <= flash_cnt_d;
      start_prev_q <= i_Game_Start;
    end
  end

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    lives_d        = lives_q;
    frog_reset_d   = 1'b0;
    flash_d        = 1'b0;
    flash_cnt_d    = flash_cnt_q;
    timer_load     = 1'b0;
    timer_load_val = '0;

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_evt) begin
          state_d      = ST_PLAY;
          level_d      = LEVEL_W'(1);
          lives_d      = LIVES_W'(LIVES_INIT);
          frog_reset_d = 1'b1;
        end
      end

      ST_PLAY: begin
        // Collision takes priority over reaching the goal row.
        if (i_Collided) begin
          state_d        = ST_DYING;
          lives_d        = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(DEATH_FRAMES);
          flash_d        = 1'b1;
          flash_cnt_d    = '0;
        end else if (i_Frog_Y == ROW_W'(GOAL_ROW)) begin
          state_d        = ST_LEVEL_UP;
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(LEVEL_FRAMES);
        end
      end

      ST_DYING: begin
        flash_d = flash_q;
        if (i_Frame_Tick) begin
          flash_cnt_d = flash_cnt_q + 3'd1;
          if (flash_cnt_q == 3'd7) flash_d = !flash_q;
        end
        if (timer_done) begin
          flash_d = 1'b0;
          if (lives_q == '0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d      = ST_PLAY;
            frog_reset_d = 1'b1;
          end
        end
      end

      ST_LEVEL_UP: begin
        if (timer_done) begin
          level_d      = level_inc_sat(level_q, LEVEL_W'(MAX_LEVEL));
          state_d      = ST_PLAY;
          frog_reset_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    move_en_d = (state_d == ST_PLAY);
    cars_en_d = (state_d == ST_PLAY) || (state_d == ST_DYING);
  end

  assign o_State      = state_q;
  assign o_Level      = level_q;
  assign o_Lives      = lives_q;
  assign o_Frog_Reset = frog_reset_q;
  assign o_Move_En    = move_en_q;
  assign o_Cars_En    = cars_en_q;
  assign o_Flash      = flash_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed bench for frogger_game_fsm with default parameters; expected values
// are hand-derived from the game rules.
module tb_frogger_game_fsm;
  import frogger_pkg::*;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_Frame_Tick;
  logic       i_Game_Start;
  logic       i_Collided;
  logic [5:0] i_Frog_Y;
  logic [2:0] o_State;
  logic [6:0] o_Level;
  logic [1:0] o_Lives;
  logic       o_Frog_Reset;
  logic       o_Move_En;
  logic       o_Cars_En;
  logic       o_Flash;

  int checks = 0;
  int errors = 0;
  logic reached;

  frogger_game_fsm dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Game_Start (i_Game_Start),
    .i_Collided   (i_Collided),
    .i_Frog_Y     (i_Frog_Y),
    .o_State      (o_State),
    .o_Level      (o_Level),
    .o_Lives      (o_Lives),
    .o_Frog_Reset (o_Frog_Reset),
    .o_Move_En    (o_Move_En),
    .o_Cars_En    (o_Cars_En),
    .o_Flash      (o_Flash)
  );

  always #5 i_Clk = !i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    i_Frame_Tick = 1'b1;
    repeat (n) step();
    i_Frame_Tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [2:0] st, input logic [6:0] lvl,
                             input logic [1:0] lv, input logic fr, input logic mv,
                             input logic ce, input logic fl);
    chk({tag, ".state"},      32'(o_State),      32'(st));
    chk({tag, ".level"},      32'(o_Level),      32'(lvl));
    chk({tag, ".lives"},      32'(o_Lives),      32'(lv));
    chk({tag, ".frog_reset"}, 32'(o_Frog_Reset), 32'(fr));
    chk({tag, ".move_en"},    32'(o_Move_En),    32'(mv));
    chk({tag, ".cars_en"},    32'(o_Cars_En),    32'(ce));
    chk({tag, ".flash"},      32'(o_Flash),      32'(fl));
  endtask

  initial begin
    i_Rst = 1'b1; i_Frame_Tick = 1'b0; i_Game_Start = 1'b0;
    i_Collided = 1'b0; i_Frog_Y = 6'd10;
    step(); step();
    chk_outputs("reset", ST_IDLE, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start press: PLAY on the next edge with a single frog reset pulse
    i_Rst = 1'b0;
    step();
    chk("idle_wait", 32'(o_State), 32'(ST_IDLE));
    i_Game_Start = 1'b1;
    step();
    chk_outputs("start", ST_PLAY, 7'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("start_one_pulse", 32'(o_Frog_Reset), 32'd0);
    chk("start_held_play", 32'(o_State), 32'(ST_PLAY));
    i_Game_Start = 1'b0;

    // First collision: 60 frames of DYING with flash toggling every 8 ticks
    i_Collided = 1'b1;
    step();
    i_Collided = 1'b0;
    chk_outputs("die1_entry", ST_DYING, 7'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    do_ticks(7);
    chk("die1_flash_t7", 32'(o_Flash), 32'd1);
    do_ticks(1);
    chk("die1_flash_t8", 32'(o_Flash), 32'd0);
    do_ticks(8);
    chk("die1_flash_t16", 32'(o_Flash), 32'd1);
    do_ticks(14);
    step(); step(); step();
    chk("die1_no_tick_hold", 32'(o_State), 32'(ST_DYING));
    do_ticks(29);
    chk("die1_t59_state", 32'(o_State), 32'(ST_DYING));
    do_ticks(1);
    chk_outputs("die1_exit", ST_PLAY, 7'd1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

    // Second and third collisions end the game
    i_Collided = 1'b1; step(); i_Collided = 1'b0;
    chk("die2_lives", 32'(o_Lives), 32'd1);
    do_ticks(60);
    chk("die2_exit_state", 32'(o_State), 32'(ST_PLAY));
    i_Collided = 1'b1; step(); i_Collided = 1'b0;
    chk("die3_lives", 32'(o_Lives), 32'd0);
    do_ticks(59);
    chk("die3_t59_state", 32'(o_State), 32'(ST_DYING));
    do_ticks(1);
    chk_outputs("game_over", ST_GAME_OVER, 7'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("game_over_hold", 32'(o_State), 32'(ST_GAME_OVER));

    i_Game_Start = 1'b1; step(); i_Game_Start = 1'b0;
    chk_outputs("restart", ST_PLAY, 7'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // Goal row and collision together: collision wins
    i_Frog_Y = 6'd0; i_Collided = 1'b1;
    step();
    i_Frog_Y = 6'd10; i_Collided = 1'b0;
    chk_outputs("goal_and_coll", ST_DYING, 7'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    i_Game_Start = 1'b1; step(); i_Game_Start = 1'b0;
    chk("start_ignored_dying", 32'(o_State), 32'(ST_DYING));
    do_ticks(60);
    chk("goal_coll_exit_state", 32'(o_State), 32'(ST_PLAY));
    chk("goal_coll_exit_level", 32'(o_Level), 32'd1);

    // Goal alone: LEVEL_UP for 90 frames, then level 2
    i_Frog_Y = 6'd0; step(); i_Frog_Y = 6'd10;
    chk_outputs("lvlup_entry", ST_LEVEL_UP, 7'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ticks(89);
    chk("lvlup_t89_state", 32'(o_State), 32'(ST_LEVEL_UP));
    chk("lvlup_t89_level", 32'(o_Level), 32'd1);
    do_ticks(1);
    chk_outputs("lvlup_exit", ST_PLAY, 7'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

    // Keep winning until level saturates at 99
    i_Frog_Y = 6'd0; i_Frame_Tick = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (o_Level == 7'd99 && o_State == 3'(ST_PLAY)) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    chk("reach_level_99", 32'(reached), 32'd1);
    step();
    chk("sat_lvlup_state", 32'(o_State), 32'(ST_LEVEL_UP));
    repeat (89) step();
    chk("sat_t89_state", 32'(o_State), 32'(ST_LEVEL_UP));
    step();
    chk("sat_exit_state", 32'(o_State), 32'(ST_PLAY));
    chk("sat_level", 32'(o_Level), 32'd99);
    i_Frog_Y = 6'd10; i_Frame_Tick = 1'b0;
    step();

    // Reset mid-DYING with start held through it
    i_Collided = 1'b1; step(); i_Collided = 1'b0;
    chk("pre_rst_state", 32'(o_State), 32'(ST_DYING));
    do_ticks(30);
    i_Game_Start = 1'b1; i_Rst = 1'b1; i_Frame_Tick = 1'b1; i_Collided = 1'b1;
    step();
    i_Frame_Tick = 1'b0; i_Collided = 1'b0;
    chk_outputs("mid_die_rst", ST_IDLE, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_Rst = 1'b0;
    step(); step();
    chk("held_start_no_evt", 32'(o_State), 32'(ST_IDLE));
    i_Game_Start = 1'b0; step();
    i_Game_Start = 1'b1; step();
    chk_outputs("post_rst_start", ST_PLAY, 7'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    i_Game_Start = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
